mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the load/store handshake (MEMEn, MEMR_W, MFC).
- Accepts a request qualified by MEMEn, using MAR as the address, MDR as the write data and MEMR_W as the direction.
- Performs the access on an internal synchronous RAM after a programmable number of wait states, then asserts MFC (memory function complete) until the requester releases MEMEn.
- Sits opposite the load/store FSM on the MAR/MDR bus.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, extra wait states inserted before MFC rises; legal range 0..15.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- MEMEn  input  1  request enable from the requester; level-held for the whole transaction.
- MEMR_W  input  1  direction: 1 = read, 0 = write; sampled at accept.
- memAddr  input  ADDR_W  address from MAR; sampled at accept.
- memDataIn  input  DATA_W  write data from MDR; sampled at accept.
- memDataOut  output  DATA_W  read data to MDR; valid while MFC=1 on a read.
- MFC  output  1  memory function complete.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, MFC=0, busy=0, memDataOut=0, wait counter=0.
  - RAM contents are not reset and are undefined until written.
- States: IDLE, WAIT, DONE, RELEASE. All outputs are registered.
- IDLE:
  - Accept occurs on a rising edge with MEMEn=1 and armed=1.
  - At accept, capture memAddr, memDataIn and MEMR_W into holding registers, load cnt=WAIT_CYCLES and go to WAIT.
  - armed is set whenever MEMEn=0 is sampled, and cleared at accept.
  - Holding MEMEn high across transactions never re-triggers. A new request requires MEMEn=0 for at least one sampled edge.
- WAIT:
  - If MEMEn=0 is sampled: abort, go to IDLE, no RAM write, MFC stays 0, memDataOut unchanged.
  - Else if cnt==0: perform the access and go to DONE with MFC=1.
    - Write: RAM[addr_q] <= data_q.
    - Read: memDataOut <= RAM[addr_q].
  - Else: cnt <= cnt-1.
- Latency:
  - For accept edge E0, MFC is first high after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives MFC one edge after accept.
- DONE:
  - MFC=1 and memDataOut stays stable.
  - Stays in DONE while MEMEn=1.
  - When MEMEn=0 is sampled, go to IDLE with MFC=0 after that edge. The RELEASE state is folded here, so the encoding is only reserved.
- A write never changes memDataOut; it keeps the last read value.
- Changes on memAddr, memDataIn or MEMR_W after accept are ignored for the current transaction.
- Reset mid-transaction:
  - Immediate return to IDLE, MFC=0.
  - A pending write in WAIT is dropped.
  - A write already committed in DONE persists.
- Unused state encodings recover to IDLE on the next edge with MFC=0.
- Address wrap-around does not exist: the full 2**ADDR_W range is decoded and all addresses are valid.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 0xBEEF to addr 0x12 (MEMR_W=0) -> MFC rises 3 edges after accept.
  - Drop MEMEn -> MFC=0 next edge.
  - Read addr 0x12 -> MFC after 3 edges with memDataOut=0xBEEF.
- WAIT_CYCLES=0: read addr 0x00 after writing 0x0001 -> MFC one edge after accept, memDataOut=0x0001.
- Abort: start a write of 0x5555 to 0x40, drop MEMEn after 1 wait edge -> MFC never rises.
  - A later read of 0x40 returns the prior value 0xAAAA.
- Held MEMEn: keep MEMEn=1 for 10 edges after MFC -> MFC stays 1 and no second access occurs.
  - memAddr changed to 0x41 during the hold -> memDataOut unchanged.
- Reset mid-WAIT: assert reset=0 asynchronously between edges during a write to 0x7F -> MFC=0 and busy=0 immediately.
  - A later read of 0x7F returns the old data.
- Boundary addresses: write 0xFFFF to 0xFF and 0x0000 to 0x00, then read both -> 0xFFFF and 0x0000 with no aliasing.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MEMEn / MEMR_W / MFC load-store handshake.
// One request per MEMEn pulse, served from an internal synchronous RAM after WAIT_CYCLES wait states.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEMEn,
    input  logic              MEMR_W,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memDataIn,
    output logic [DATA_W-1:0] memDataOut,
    output logic              MFC,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mfc_q, mfc_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q;
    logic              ram_we;
    logic              ram_re;

    logic [DATA_W-1:0] ram [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        // Re-arming on any idle-low sample keeps a held MEMEn from re-triggering.
        if (!MEMEn) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (MEMEn && armed_q) begin
                    rw_d    = MEMR_W;
                    addr_d  = memAddr;
                    data_d  = memDataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    armed_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!MEMEn) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    ram_we  = !rw_q;
                    ram_re  = rw_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!MEMEn) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        mfc_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            armed_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mfc_q   <= mfc_d;
            busy_q  <= busy_d;
        end
    end

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr_q] <= data_q;
        end
    end

    // Registered read port doubles as the output register, so it holds across writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (ram_re) begin
            rdata_q <= ram[addr_q];
        end
    end

    assign memDataOut = rdata_q;
    assign MFC        = mfc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with none.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en2 = 1'b0;
    logic        en0 = 1'b0;
    logic        mem_rw = 1'b1;
    logic [7:0]  mem_addr = 8'h00;
    logic [15:0] mem_din = 16'h0000;
    logic [15:0] dout2, dout0;
    logic        mfc2, mfc0, busy2, busy0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .MEMEn(en2), .MEMR_W(mem_rw),
        .memAddr(mem_addr), .memDataIn(mem_din),
        .memDataOut(dout2), .MFC(mfc2), .busy(busy2)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .MEMEn(en0), .MEMR_W(mem_rw),
        .memAddr(mem_addr), .memDataIn(mem_din),
        .memDataOut(dout0), .MFC(mfc0), .busy(busy0)
    );

    typedef struct {
        bit          sel;    // 1 = zero-wait instance
        bit          rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          lat;    // edges from accept to MFC high
        logic [15:0] rdata;  // memDataOut while MFC=1
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_mfc(input bit sel);
        return sel ? mfc0 : mfc2;
    endfunction

    function automatic logic sel_busy(input bit sel);
        return sel ? busy0 : busy2;
    endfunction

    function automatic logic [15:0] sel_dout(input bit sel);
        return sel ? dout0 : dout2;
    endfunction

    task automatic start(input bit sel, input bit rw, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_rw   = rw;
        mem_addr = a;
        mem_din  = d;
        if (sel) en0 = 1'b1; else en2 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mfc(input bit sel, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sel_mfc(sel) && n < 40);
        if (!sel_mfc(sel)) n = -1;
    endtask

    task automatic drop(input bit sel);
        @(negedge clk);
        if (sel) en0 = 1'b0; else en2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [15:0] rd;

        vecs[0]  = '{0, 0, 8'h12, 16'hBEEF, 3, 16'h0000};
        vecs[1]  = '{0, 1, 8'h12, 16'h0000, 3, 16'hBEEF};
        vecs[2]  = '{1, 0, 8'h00, 16'h0001, 1, 16'h0000};
        vecs[3]  = '{1, 1, 8'h00, 16'h0000, 1, 16'h0001};
        vecs[4]  = '{0, 0, 8'h40, 16'hAAAA, 3, 16'hBEEF};
        vecs[5]  = '{0, 0, 8'hFF, 16'hFFFF, 3, 16'hBEEF};
        vecs[6]  = '{0, 0, 8'h00, 16'h0000, 3, 16'hBEEF};
        vecs[7]  = '{0, 1, 8'hFF, 16'h0000, 3, 16'hFFFF};
        vecs[8]  = '{0, 1, 8'h00, 16'h0000, 3, 16'h0000};
        vecs[9]  = '{0, 0, 8'h7F, 16'h1234, 3, 16'h0000};
        vecs[10] = '{0, 0, 8'h41, 16'h4141, 3, 16'h0000};
        vecs[11] = '{0, 1, 8'h40, 16'h0000, 3, 16'hAAAA};
        vecs[12] = '{1, 1, 8'h00, 16'h0000, 1, 16'h0001};

        repeat (2) @(posedge clk);
        #1;
        check("reset_mfc", {30'd0, mfc2, mfc0}, 32'd0);
        check("reset_busy", {30'd0, busy2, busy0}, 32'd0);
        check("reset_dout", {dout2, dout0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            start(vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            wait_mfc(vecs[i].sel, n);
            rd = sel_dout(vecs[i].sel);
            check($sformatf("v%0d_latency", i), n, vecs[i].lat);
            check($sformatf("v%0d_dout", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_busy", i), sel_busy(vecs[i].sel), 1'b1);
            drop(vecs[i].sel);
            check($sformatf("v%0d_release", i), {sel_mfc(vecs[i].sel), sel_busy(vecs[i].sel)}, 2'b00);
            $display("vec %0d sel=%0d rw=%0d addr=%02h wdata=%04h lat=%0d dout=%04h",
                     i, vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].wdata, n, rd);
        end

        // Abort after one wait edge: no MFC, no write.
        start(0, 0, 8'h40, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        en2 = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mfc2) n++;
        end
        check("abort_mfc_count", n, 0);
        check("abort_busy", busy2, 1'b0);
        start(0, 1, 8'h40, 16'h0000);
        wait_mfc(0, n);
        check("abort_readback", dout2, 16'hAAAA);
        drop(0);
        $display("abort sequence: readback 0x40 = %04h", dout2);

        // Hold MEMEn after MFC while the request bus changes underneath.
        start(0, 1, 8'h12, 16'h0000);
        wait_mfc(0, n);
        check("hold_latency", n, 3);
        @(negedge clk);
        mem_addr = 8'h41;
        mem_rw   = 1'b0;
        mem_din  = 16'hDEAD;
        n = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mfc2 !== 1'b1 || dout2 !== 16'hBEEF) n++;
        end
        check("hold_stable_errs", n, 0);
        drop(0);
        start(0, 1, 8'h41, 16'h0000);
        wait_mfc(0, n);
        check("hold_no_second_write", dout2, 16'h4141);
        drop(0);
        $display("hold sequence: readback 0x41 = %04h", dout2);

        // Asynchronous reset in the middle of a pending write.
        start(0, 0, 8'h7F, 16'h5A5A);
        check("rst_mid_busy_before", busy2, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_mfc", mfc2, 1'b0);
        check("rst_mid_busy", busy2, 1'b0);
        check("rst_mid_dout", dout2, 16'h0000);
        en2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        start(0, 1, 8'h7F, 16'h0000);
        wait_mfc(0, n);
        check("rst_mid_latency", n, 3);
        check("rst_mid_readback", dout2, 16'h1234);
        drop(0);
        $display("reset sequence: readback 0x7F = %04h", dout2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
